// File: rtl/setting_mode_sequencer_pkg.sv
// setting_mode_sequencer_pkg: shared mode, field and default constants for the setting session
package setting_mode_sequencer_pkg;
  localparam int MODE_WIDTH = 3;
  localparam logic [MODE_WIDTH-1:0] STAND_MODE = 3'd1;
  localparam logic [1:0] FIELD_HOUR = 2'd0;
  localparam logic [1:0] FIELD_MIN = 2'd1;
  localparam logic [1:0] FIELD_REMIND = 2'd2;
  localparam logic [1:0] FIELD_GESTURE = 2'd3;
  localparam logic [4:0] DEF_REMIND_HOURS = 5'd10;
  localparam logic [3:0] DEF_GESTURE_SEC = 4'd5;
  typedef enum logic [2:0] {S_IDLE, S_HOUR, S_MIN, S_REMIND, S_GESTURE} state_t;
endpackage

// File: rtl/setting_mode_sequencer_key_edge_detect.sv
// key_edge_detect: rising-edge pulse from a key level with a clearable history
module key_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic level,
  output logic rise
);
  logic prev;
  // History follows the key level so a key already held produces no edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev <= 1'b0;
    else prev <= clr ? 1'b0 : level;
  end
  assign rise = level & ~prev;
endmodule

// File: rtl/setting_mode_sequencer.sv
// setting_mode_sequencer: standby user-setting session for clock, reminder and gesture values
module setting_mode_sequencer
  import setting_mode_sequencer_pkg::*;
#(
  parameter int TIMEOUT_S = 10,
  parameter int REMIND_MAX = 10,
  parameter int GESTURE_MIN = 2,
  parameter int GESTURE_MAX = 9
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MODE_WIDTH-1:0] current_mode,
  input  logic                  enter_toggle,
  input  logic                  key_next,
  input  logic                  key_inc,
  input  logic                  key_dec,
  input  logic                  tick_1s,
  input  logic [4:0]            cur_hour,
  input  logic [5:0]            cur_min,
  output logic                  setting_active,
  output logic [1:0]            field_sel,
  output logic [5:0]            edit_value,
  output logic                  clock_load,
  output logic [4:0]            set_hour,
  output logic [5:0]            set_min,
  output logic [4:0]            remind_hours,
  output logic [3:0]            gesture_sec
);
  localparam logic [5:0] TMO = 6'(TIMEOUT_S);
  localparam logic [4:0] RMAX = 5'(REMIND_MAX);
  localparam logic [3:0] GMIN = 4'(GESTURE_MIN);
  localparam logic [3:0] GMAX = 4'(GESTURE_MAX);
  state_t state, state_nx;
  logic [5:0] tmo_cnt, e_min;
  logic [4:0] e_hour, e_rem;
  logic [3:0] e_ges;
  logic nx_rise, inc_rise, dec_rise;
  logic active, in_stand, start, abort, commit, tmo, quiet, do_next, do_key, inc_ok, dec_ok;
  assign active = state != S_IDLE;
  assign in_stand = current_mode == STAND_MODE;
  assign start = !active && enter_toggle && in_stand;
  assign abort = active && !in_stand;
  assign commit = active && in_stand && enter_toggle;
  assign tmo = active && in_stand && !enter_toggle && tmo_cnt == TMO;
  assign quiet = active && in_stand && !enter_toggle && !tmo;
  assign do_next = quiet && nx_rise;
  assign do_key = quiet && !nx_rise && (inc_rise || dec_rise);
  assign inc_ok = do_key && inc_rise && !dec_rise;
  assign dec_ok = do_key && dec_rise && !inc_rise;
  key_edge_detect u_next (.clk(clk), .rstn(rstn), .clr(abort || tmo), .level(key_next), .rise(nx_rise));
  key_edge_detect u_inc (.clk(clk), .rstn(rstn), .clr(abort || tmo), .level(key_inc), .rise(inc_rise));
  key_edge_detect u_dec (.clk(clk), .rstn(rstn), .clr(abort || tmo), .level(key_dec), .rise(dec_rise));
  // Session state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else state <= state_nx;
  end
  // Next state: entry, then abort/commit/timeout to idle, then field rotation
  always_comb begin
    state_nx = state;
    if (start) state_nx = S_HOUR;
    else if (abort || commit || tmo) state_nx = S_IDLE;
    else if (do_next) state_nx = state == S_HOUR ? S_MIN : state == S_MIN ? S_REMIND : state == S_REMIND ? S_GESTURE : S_HOUR;
  end
  // Idle-seconds counter, restarted on entry and on every accepted key edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_cnt <= 6'd0;
    else if (start || do_next || do_key) tmo_cnt <= 6'd0;
    else if (active && tick_1s && tmo_cnt != TMO) tmo_cnt <= tmo_cnt + 6'd1;
  end
  // Hour edit register, clamped on load, wraps 23<->0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) e_hour <= 5'd0;
    else if (start) e_hour <= cur_hour > 5'd23 ? 5'd23 : cur_hour;
    else if (inc_ok && state == S_HOUR) e_hour <= e_hour >= 5'd23 ? 5'd0 : e_hour + 5'd1;
    else if (dec_ok && state == S_HOUR) e_hour <= e_hour == 5'd0 ? 5'd23 : e_hour - 5'd1;
  end
  // Minute edit register, clamped on load, wraps 59<->0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) e_min <= 6'd0;
    else if (start) e_min <= cur_min > 6'd59 ? 6'd59 : cur_min;
    else if (inc_ok && state == S_MIN) e_min <= e_min >= 6'd59 ? 6'd0 : e_min + 6'd1;
    else if (dec_ok && state == S_MIN) e_min <= e_min == 6'd0 ? 6'd59 : e_min - 6'd1;
  end
  // Reminder edit register, wraps REMIND_MAX<->1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) e_rem <= 5'd0;
    else if (start) e_rem <= remind_hours;
    else if (inc_ok && state == S_REMIND) e_rem <= e_rem >= RMAX ? 5'd1 : e_rem + 5'd1;
    else if (dec_ok && state == S_REMIND) e_rem <= e_rem <= 5'd1 ? RMAX : e_rem - 5'd1;
  end
  // Gesture edit register, wraps GESTURE_MAX<->GESTURE_MIN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) e_ges <= 4'd0;
    else if (start) e_ges <= gesture_sec;
    else if (inc_ok && state == S_GESTURE) e_ges <= e_ges >= GMAX ? GMIN : e_ges + 4'd1;
    else if (dec_ok && state == S_GESTURE) e_ges <= e_ges <= GMIN ? GMAX : e_ges - 4'd1;
  end
  // Committed values and the one-cycle clock load pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clock_load <= 1'b0;
      set_hour <= 5'd0;
      set_min <= 6'd0;
      remind_hours <= DEF_REMIND_HOURS;
      gesture_sec <= DEF_GESTURE_SEC;
    end else begin
      clock_load <= commit;
      if (commit) begin
        set_hour <= e_hour;
        set_min <= e_min;
        remind_hours <= e_rem;
        gesture_sec <= e_ges;
      end
    end
  end
  assign setting_active = active;
  assign field_sel = state == S_MIN ? FIELD_MIN : state == S_REMIND ? FIELD_REMIND : state == S_GESTURE ? FIELD_GESTURE : FIELD_HOUR;
  assign edit_value = state == S_HOUR ? {1'b0, e_hour} : state == S_MIN ? e_min : state == S_REMIND ? {1'b0, e_rem} : state == S_GESTURE ? {2'b0, e_ges} : 6'd0;
endmodule
